// File: rtl/write_back_block.sv
// Write-back stage register for the 16-bit pipelined MIPS datapath.
// A DEPTH-stage retiming pipe carries ans_dm to ans_wb, with a valid bit travelling alongside each stage.
module write_back_block #(
  parameter int              WIDTH       = 16,
  parameter int              DEPTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ans_dm,
  output logic [WIDTH-1:0] ans_wb,
  output logic             wb_valid
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;

  // Each stage loads from its predecessor. Stage 0 loads from the input.
  always_comb begin
    stage_d[0] = ans_dm;
    valid_d    = '0;
    valid_d[0] = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
      valid_d[i] = valid_q[i-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Every stage is
  // reset, not only the last one. If any stage were left unreset, stale
  // pre-reset data could surface on ans_wb a few edges after reset releases.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESET_VALUE;
      end
      valid_q <= '0;
    end else begin
      stage_q <= stage_d;
      valid_q <= valid_d;
    end
  end

  assign ans_wb   = stage_q[DEPTH-1];
  assign wb_valid = valid_q[DEPTH-1];

endmodule

// File: tb/tb_write_back_block.sv
// Scoreboard bench for write_back_block. It runs a DEPTH=1 instance against timed directed
// events, then a DEPTH=3 / RESET_VALUE=0x00FF instance against a per-edge vector table.
module tb_write_back_block;

  logic        clk = 1'b0;
  logic        reset1, reset3;
  logic [15:0] dm1, dm3;
  logic [15:0] wb1, wb3;
  logic        vld1, vld3;

  int n_checks = 0;
  int n_errors = 0;

  // Each entry holds the expected {wb_valid, ans_wb} for one rising edge.
  logic [16:0] exp1_q [$];
  logic [16:0] exp3_q [$];
  logic [16:0] e1, e3;

  always #5 clk = ~clk;

  write_back_block #(.WIDTH(16), .DEPTH(1), .RESET_VALUE(16'h0000)) u_d1 (
    .clk(clk), .reset(reset1), .ans_dm(dm1), .ans_wb(wb1), .wb_valid(vld1)
  );

  write_back_block #(.WIDTH(16), .DEPTH(3), .RESET_VALUE(16'h00FF)) u_d3 (
    .clk(clk), .reset(reset3), .ans_dm(dm3), .ans_wb(wb3), .wb_valid(vld3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_until(input longint t);
    #(t - longint'($time));
  endtask

  // The monitors sample 1 time unit after each rising edge and pop when an expectation is queued.
  always @(posedge clk) begin
    #1;
    if (exp1_q.size() > 0) begin
      e1 = exp1_q.pop_front();
      check("d1_out{valid,wb}", {15'd0, vld1, wb1}, {15'd0, e1});
    end
  end

  always @(posedge clk) begin
    #1;
    if (exp3_q.size() > 0) begin
      e3 = exp3_q.pop_front();
      check("d3_out{valid,wb}", {15'd0, vld3, wb3}, {15'd0, e3});
    end
  end

  typedef struct packed {
    logic        rst;
    logic [15:0] dm;
    logic        exp_v;
    logic [15:0] exp_wb;
  } vec3_t;

  vec3_t vec3 [10];

  initial begin
    vec3[0] = '{1'b1, 16'hAAAA, 1'b0, 16'h00FF};
    vec3[1] = '{1'b0, 16'h1234, 1'b0, 16'h00FF};
    vec3[2] = '{1'b0, 16'h5678, 1'b0, 16'h00FF};
    vec3[3] = '{1'b0, 16'h9ABC, 1'b1, 16'h1234};
    vec3[4] = '{1'b0, 16'hDEF0, 1'b1, 16'h5678};
    vec3[5] = '{1'b1, 16'h0F0F, 1'b0, 16'h00FF};
    vec3[6] = '{1'b0, 16'h4321, 1'b0, 16'h00FF};
    vec3[7] = '{1'b0, 16'h1111, 1'b0, 16'h00FF};
    vec3[8] = '{1'b0, 16'h2222, 1'b1, 16'h4321};
    vec3[9] = '{1'b1, 16'h3333, 1'b0, 16'h00FF};

    reset1 = 1'b1; dm1 = 16'h0034;
    reset3 = 1'b1; dm3 = 16'h0000;

    // DEPTH=1: the timed scenario begins here. Rising edges fall at t=5, 15, 25, ...
    wait_until(2);  reset1 = 1'b0; exp1_q.push_back({1'b1, 16'h0034});
    wait_until(8);  reset1 = 1'b1; dm1 = 16'h1111; exp1_q.push_back({1'b0, 16'h0000});
    wait_until(13); dm1 = 16'h3331;
    wait_until(18); exp1_q.push_back({1'b0, 16'h0000});
    wait_until(28); reset1 = 1'b0; dm1 = 16'hAAAA; exp1_q.push_back({1'b1, 16'hAAAA});
    wait_until(31); reset1 = 1'b1;
    wait_until(33); reset1 = 1'b0;
    wait_until(38); dm1 = 16'h5555; exp1_q.push_back({1'b1, 16'h5555});
    wait_until(48); dm1 = 16'hFFFF; exp1_q.push_back({1'b1, 16'hFFFF});
    wait_until(58); dm1 = 16'h0001; exp1_q.push_back({1'b1, 16'h0002});
    wait_until(60); dm1 = 16'h0002;
    wait_until(62); dm1 = 16'h0001;
    wait_until(64); dm1 = 16'h0002;
    wait_until(66); dm1 = 16'h0001; exp1_q.push_back({1'b1, 16'h0001});
    wait_until(70); dm1 = 16'h0002;
    wait_until(73); dm1 = 16'h0001;

    // DEPTH=3, RESET_VALUE=0x00FF: each vector is applied on the falling edge before the rising edge it targets.
    wait_until(80);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      reset3 = vec3[i].rst;
      dm3    = vec3[i].dm;
      exp3_q.push_back({vec3[i].exp_v, vec3[i].exp_wb});
    end

    for (int k = 0; k < 10 && (exp1_q.size() + exp3_q.size()) > 0; k++) @(negedge clk);
    check("d1_drain", 32'(exp1_q.size()), 32'd0);
    check("d3_drain", 32'(exp3_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/write_back_block.md
Name: write_back_block

Overview:
- Write-back stage register of the 16-bit pipelined MIPS datapath.
- Captures the result from the data-memory stage (ans_dm) on each rising clock edge and presents it as the write-back value (ans_wb) for the register-file write port.
- A configurable pipeline depth and a valid flag allow the same block to be reused where extra retiming is needed.
- Default configuration is a single 16-bit register.

Parameters:
- WIDTH, 16, data width of ans_dm / ans_wb.
- DEPTH, 1, number of register stages between ans_dm and ans_wb; legal range 1..8.
- RESET_VALUE, 0 (WIDTH bits), value loaded into every stage while reset is high.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- ans_dm  input  WIDTH  result from the data-memory stage.
- ans_wb  output  WIDTH  registered write-back value; driven directly from the last stage register.
- wb_valid  output  1  high when ans_wb holds data captured after reset release, not RESET_VALUE fill. This is an optional port and may be left unconnected.

Behaviour:
- One clock domain. Reset is synchronous and active-high, sampled only at the rising edge of clk. There is no asynchronous path.
- At a rising edge with reset=1:
  - every stage register <= RESET_VALUE, so ans_wb = 0x0000 by default;
  - the valid pipeline is cleared, so wb_valid = 0.
- At a rising edge with reset=0:
  - stage[0] <= ans_dm and stage[i] <= stage[i-1];
  - ans_wb = stage[DEPTH-1];
  - the valid bit shifts in a 1 alongside the data.
- Latency: exactly DEPTH rising edges from ans_dm to ans_wb. With DEPTH=1, ans_wb at edge n equals ans_dm sampled at edge n.
- Reset and data at the same edge: reset wins, and the ans_dm value at that edge is discarded.
- Reset mid-operation: all in-flight data is flushed at the first edge where reset=1. After reset deasserts, wb_valid rises DEPTH edges later.
- Reset pulses that begin and end between two rising edges have no effect.
- ans_dm changes between edges have no effect. The output changes only at rising edges; there is no combinational path from ans_dm or reset to ans_wb.
- Before the first rising edge the output value is undefined. Benches must not check ans_wb before the first edge.
- No arithmetic is performed; data passes through bit-exact at WIDTH bits.
- No enable or stall input: the block captures every cycle.

Test Plan:
- Setup: DEPTH=1, clock period 10 ns, first rising edge at t=5.
- Reset then release: reset=1, ans_dm=0x0034 at t=0; reset=0 at t=2; edge at t=5 -> ans_wb=0x0034, wb_valid=1.
- Reset reassert with data change: reset=1 and ans_dm=0x1111 at t=8; edge at t=15 -> ans_wb=0x0000, wb_valid=0 (reset beats data).
- Data change while held in reset: ans_dm=0x3331 at t=13, reset still 1; edges at t=15 and t=25 -> ans_wb stays 0x0000.
- Streaming: reset=0, ans_dm = 0xAAAA, 0x5555, 0xFFFF on three consecutive edges -> ans_wb shows the same sequence, each value at the edge that samples it.
- Glitch immunity: ans_dm toggles 0x0001/0x0002 between edges -> ans_wb shows only values present at rising edges. A reset pulse from t=31 to t=33 (between edges) -> no effect on ans_wb.
- DEPTH=3 with RESET_VALUE=0x00FF:
  - during reset -> ans_wb=0x00FF;
  - after release, first data 0x1234 -> appears 3 edges later, with wb_valid rising on that same edge;
  - reset asserted mid-stream -> all stages flushed to 0x00FF at one edge.
